// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: time-shares one external combinational WIDTH-bit adder
// between two requesters. Operands are registered and presented to the adder
// for one CALC cycle. The adder's sum, overflow and carry are captured and then
// returned on the owning port's response channel. Both the request and the
// response channels use valid/ready handshakes.
module adder_share_ctrl #(
  parameter int WIDTH = 32,
  parameter bit RR    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_sub,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_ovf,
  output logic             rsp_cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_ovf,
  input  logic             add_cout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_cout_q, rsp_cout_d;

  logic [1:0]         grant_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic               sel_sub_s;

  // Arbitration: a lone requester wins; a tie goes to round-robin or to port 0
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11: begin
        if (RR) begin
          grant_s = last_grant_q ? 2'b01 : 2'b10;
        end else begin
          grant_s = 2'b01;
        end
      end
      default: grant_s = 2'b00;
    endcase
  end

  // Operand mux: select the winning port's operands and operation
  always_comb begin
    sel_a_s   = req_a0;
    sel_b_s   = req_b0;
    sel_sub_s = req_sub[0];
    if (grant_s[1]) begin
      sel_a_s   = req_a1;
      sel_b_s   = req_b1;
      sel_sub_s = req_sub[1];
    end else begin
      sel_a_s   = req_a0;
      sel_b_s   = req_b0;
      sel_sub_s = req_sub[0];
    end
  end

  // Next-state and output decode of the IDLE -> CALC -> RESP sequencer
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    add_cin_d    = add_cin_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_cout_d   = rsp_cout_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant_s;
        if (grant_s != 2'b00) begin
          owner_d      = grant_s[1];
          last_grant_d = grant_s[1];
          add_a_d      = sel_a_s;
          // Subtract is A + ~B + 1: invert B here, the carry-in supplies the +1
          add_b_d      = sel_sub_s ? ~sel_b_s : sel_b_s;
          add_cin_d    = sel_sub_s;
          state_d      = ST_CALC;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_CALC: begin
        rsp_sum_d  = add_s;
        rsp_ovf_d  = add_ovf;
        rsp_cout_d = add_cout;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      add_a_q      <= {WIDTH{1'b0}};
      add_b_q      <= {WIDTH{1'b0}};
      add_cin_q    <= 1'b0;
      rsp_sum_q    <= {WIDTH{1'b0}};
      rsp_ovf_q    <= 1'b0;
      rsp_cout_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      add_cin_q    <= add_cin_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_cout_q   <= rsp_cout_d;
    end
  end

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign add_cin  = add_cin_q;
  assign rsp_sum  = rsp_sum_q;
  assign rsp_ovf  = rsp_ovf_q;
  assign rsp_cout = rsp_cout_q;

endmodule
